// File: rtl/palette_pkg.sv
// palette_pkg: types and width helpers shared by the palette bank and its scaler.
//   fade_state_e : brightness-fade controller states
//   wr_state_e   : table write controller states (INIT clears the table, then READY)
//   rgb_w()      : packed {R,G,B} entry width for a given channel width
//   bank_w()     : bank-select width, never narrower than one bit
package palette_pkg;

  typedef enum logic [1:0] {
    FADE_FULL  = 2'd0,
    FADE_OUT   = 2'd1,
    FADE_BLACK = 2'd2,
    FADE_IN    = 2'd3
  } fade_state_e;

  typedef enum logic {
    WR_INIT  = 1'b0,
    WR_READY = 1'b1
  } wr_state_e;

  function automatic int rgb_w(input int ch_w);
    return 3 * ch_w;
  endfunction

  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/palette_scaler.sv
// palette_scaler: scales one colour channel by the fade level, y = (c * level) >> CH_W.
//   c     : channel value, CH_W bits
//   level : fade level 0..2**CH_W, CH_W+1 bits
//   y     : scaled channel; equals c exactly when level = 2**CH_W
module palette_scaler #(
  parameter int CH_W = 4
) (
  input  logic [CH_W-1:0] c,
  input  logic [CH_W:0]   level,
  output logic [CH_W-1:0] y
);

  logic [2*CH_W:0] prod_s;

  // Full-width product; the top bit is always 0 because c < 2**CH_W.
  assign prod_s = {{CH_W{1'b0}}, level} * {{(CH_W+1){1'b0}}, c};
  assign y      = CH_W'(prod_s >> CH_W);

endmodule

// File: rtl/palette_bank.sv
// palette_bank: banked colour palette with a 3-stage lookup pipeline and a frame-based fade.
//   Clk, Reset_n                    : clock, asynchronous active-low reset
//   pix_valid/pix_bank/pix_index    : lookup request, one per cycle, result 3 edges later
//   out_valid/red/green/blue/transparent : scaled lookup result (held while out_valid = 0)
//   wr_valid/wr_ready/wr_bank/wr_index/wr_color : table write port, {R,G,B} colour
//   fade_start/fade_dir/frame_tick  : fade control (dir 0 = to black, 1 = from black)
//   fade_busy/fade_level            : fade status, level 0..2**CH_W
module palette_bank
  import palette_pkg::*;
#(
  parameter  int INDEX_W   = 4,
  parameter  int NUM_BANKS = 4,
  parameter  int CH_W      = 4,
  parameter  int TRANSP_EN = 1,
  localparam int BANK_W    = bank_w(NUM_BANKS),
  localparam int COLOR_W   = rgb_w(CH_W)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               pix_valid,
  input  logic [BANK_W-1:0]  pix_bank,
  input  logic [INDEX_W-1:0] pix_index,
  output logic               out_valid,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               transparent,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               fade_start,
  input  logic               fade_dir,
  input  logic               frame_tick,
  output logic               fade_busy,
  output logic [CH_W:0]      fade_level
);

  localparam int ADDR_W = BANK_W + INDEX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** INDEX_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W:0]     LEVEL_MAX     = {1'b1, {CH_W{1'b0}}};
  localparam logic [CH_W:0]     LEVEL_ZERO    = {(CH_W+1){1'b0}};
  localparam logic [CH_W:0]     LEVEL_ONE     = {{CH_W{1'b0}}, 1'b1};
  localparam logic [CH_W:0]     LEVEL_PRE_MAX = {1'b0, {CH_W{1'b1}}};

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  rgb_t              mem_r [DEPTH];
  rgb_t              rd_data_r;
  wr_state_e         wr_state_r, wr_state_s;
  logic [ADDR_W-1:0] init_addr_r, init_addr_s;
  fade_state_e       fade_state_r, fade_state_s;
  logic [CH_W:0]     fade_level_s;
  logic [ADDR_W-1:0] wr_addr_s, pix_addr_s;
  logic              wr_commit_s;
  logic              v1_r, transp1_r, v2_r, transp2_r;
  logic [CH_W:0]     level1_r;
  logic [CH_W-1:0]   red_s, green_s, blue_s;
  logic [CH_W-1:0]   red2_r, green2_r, blue2_r;

  assign wr_addr_s   = {wr_bank, wr_index};
  assign pix_addr_s  = {pix_bank, pix_index};
  assign wr_commit_s = wr_valid && wr_ready && (wr_addr_s <= LAST_ADDR);

  // Write controller next state: walk the clear address up to the last entry, then READY.
  always_comb begin
    wr_state_s  = wr_state_r;
    init_addr_s = init_addr_r;
    case (wr_state_r)
      WR_INIT: begin
        if (init_addr_r == LAST_ADDR) begin
          wr_state_s = WR_READY;
        end else begin
          init_addr_s = init_addr_r + ADDR_ONE;
        end
      end
      WR_READY: begin
        wr_state_s = WR_READY;
      end
      default: begin
        wr_state_s  = WR_INIT;
        init_addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Write controller state, clear address and registered wr_ready.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_state_r  <= WR_INIT;
      init_addr_r <= {ADDR_W{1'b0}};
      wr_ready    <= 1'b0;
    end else begin
      wr_state_r  <= wr_state_s;
      init_addr_r <= init_addr_s;
      wr_ready    <= (wr_state_s == WR_READY);
    end
  end

  // Table storage: the read samples the pre-write contents, giving read-before-write.
  always_ff @(posedge Clk) begin
    if (wr_state_r == WR_INIT) begin
      mem_r[init_addr_r] <= {COLOR_W{1'b0}};
    end else if (wr_commit_s) begin
      mem_r[wr_addr_s] <= rgb_t'(wr_color);
    end
    rd_data_r <= (pix_addr_s <= LAST_ADDR) ? mem_r[pix_addr_s] : {COLOR_W{1'b0}};
  end

  // Fade next state: ticks move the level one step; a start only acts when idle.
  always_comb begin
    fade_state_s = fade_state_r;
    fade_level_s = fade_level;
    case (fade_state_r)
      FADE_FULL, FADE_BLACK: begin
        if (fade_start) begin
          fade_state_s = fade_dir ? FADE_IN : FADE_OUT;
        end else begin
          fade_state_s = fade_state_r;
        end
      end
      FADE_OUT: begin
        if (!frame_tick) begin
          fade_state_s = FADE_OUT;
        end else if (fade_level == LEVEL_ZERO) begin
          fade_state_s = FADE_BLACK;
        end else begin
          fade_level_s = fade_level - LEVEL_ONE;
          fade_state_s = (fade_level == LEVEL_ONE) ? FADE_BLACK : FADE_OUT;
        end
      end
      FADE_IN: begin
        if (!frame_tick) begin
          fade_state_s = FADE_IN;
        end else if (fade_level == LEVEL_MAX) begin
          fade_state_s = FADE_FULL;
        end else begin
          fade_level_s = fade_level + LEVEL_ONE;
          fade_state_s = (fade_level == LEVEL_PRE_MAX) ? FADE_FULL : FADE_IN;
        end
      end
      default: begin
        fade_state_s = FADE_FULL;
        fade_level_s = LEVEL_MAX;
      end
    endcase
  end

  // Fade state, level and registered busy flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fade_state_r <= FADE_FULL;
      fade_level   <= LEVEL_MAX;
      fade_busy    <= 1'b0;
    end else begin
      fade_state_r <= fade_state_s;
      fade_level   <= fade_level_s;
      fade_busy    <= (fade_state_s == FADE_OUT) || (fade_state_s == FADE_IN);
    end
  end

  // Stage 1: request valid, transparency and fade level captured with the table read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1_r      <= 1'b0;
      transp1_r <= 1'b0;
      level1_r  <= LEVEL_MAX;
    end else begin
      v1_r      <= pix_valid;
      transp1_r <= (TRANSP_EN != 0) && (pix_index == {INDEX_W{1'b0}});
      level1_r  <= fade_level;
    end
  end

  palette_scaler #(.CH_W(CH_W)) u_scale_r (.c(rd_data_r.r), .level(level1_r), .y(red_s));
  palette_scaler #(.CH_W(CH_W)) u_scale_g (.c(rd_data_r.g), .level(level1_r), .y(green_s));
  palette_scaler #(.CH_W(CH_W)) u_scale_b (.c(rd_data_r.b), .level(level1_r), .y(blue_s));

  // Stage 2: scaled colour registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v2_r      <= 1'b0;
      transp2_r <= 1'b0;
      red2_r    <= {CH_W{1'b0}};
      green2_r  <= {CH_W{1'b0}};
      blue2_r   <= {CH_W{1'b0}};
    end else begin
      v2_r      <= v1_r;
      transp2_r <= transp1_r;
      red2_r    <= red_s;
      green2_r  <= green_s;
      blue2_r   <= blue_s;
    end
  end

  // Stage 3: outputs update only with a valid result, otherwise they hold.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      red         <= {CH_W{1'b0}};
      green       <= {CH_W{1'b0}};
      blue        <= {CH_W{1'b0}};
      transparent <= 1'b0;
    end else begin
      out_valid <= v2_r;
      if (v2_r) begin
        red         <= red2_r;
        green       <= green2_r;
        blue        <= blue2_r;
        transparent <= transp2_r;
      end
    end
  end

endmodule

// File: tb/tb_palette_bank.sv
// tb_palette_bank: directed self-checking bench for palette_bank at default parameters.
module tb_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid;
  logic [1:0]  pix_bank;
  logic [3:0]  pix_index;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_color;
  logic        fade_start, fade_dir, frame_tick;
  logic        fade_busy;
  logic [4:0]  fade_level;

  int compared   = 0;
  int mismatched = 0;
  int cyc_cnt    = 0;

  palette_bank dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid), .pix_bank(pix_bank), .pix_index(pix_index),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue), .transparent(transparent),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_color(wr_color),
    .fade_start(fade_start), .fade_dir(fade_dir), .frame_tick(frame_tick),
    .fade_busy(fade_busy), .fade_level(fade_level)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic write_entry(input logic [1:0] b, input logic [3:0] i, input logic [11:0] c);
    wr_valid = 1'b1; wr_bank = b; wr_index = i; wr_color = c;
    cycle();
    wr_valid = 1'b0;
  endtask

  // Single lookup; also checks that the result is not early and arrives after edge N+2.
  task automatic lookup(input logic [1:0] b, input logic [3:0] i, input string tag,
                        output logic [11:0] rgb, output logic t);
    pix_valid = 1'b1; pix_bank = b; pix_index = i;
    cycle();
    pix_valid = 1'b0;
    cycle();
    check({tag, " early"}, 16'(out_valid), 16'd0);
    cycle();
    check({tag, " valid"}, 16'(out_valid), 16'd1);
    rgb = {red, green, blue};
    t   = transparent;
  endtask

  task automatic pulse(input logic start, input logic dir, input logic tick);
    fade_start = start; fade_dir = dir; frame_tick = tick;
    cycle();
    fade_start = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic wait_ready(input int start, input string tag);
    for (int n = 0; n < 200; n++) begin
      if (wr_ready) break;
      cycle();
    end
    check({tag, " ready"}, 16'(wr_ready), 16'd1);
    check({tag, " cycles"}, 16'(cyc_cnt - start), 16'd64);
  endtask

  initial begin
    logic [11:0] rgb;
    logic        t;
    logic [4:0]  lvl;
    logic [3:0]  e;
    int          start;

    Reset_n = 1'b0; pix_valid = 1'b0; pix_bank = 2'd0; pix_index = 4'd0;
    wr_valid = 1'b0; wr_bank = 2'd0; wr_index = 4'd0; wr_color = 12'h000;
    fade_start = 1'b0; fade_dir = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge Clk);

    check("rst out_valid", 16'(out_valid), 16'd0);
    check("rst wr_ready", 16'(wr_ready), 16'd0);
    check("rst fade_busy", 16'(fade_busy), 16'd0);
    check("rst fade_level", 16'(fade_level), 16'd16);
    check("rst rgb", 16'({red, green, blue}), 16'h000);
    check("rst transparent", 16'(transparent), 16'd0);

    Reset_n = 1'b1;
    start = cyc_cnt;
    wait_ready(start, "init1");

    lookup(2'd3, 4'd15, "clr b3i15", rgb, t);
    check("clr b3i15 rgb", 16'(rgb), 16'h000);
    check("clr b3i15 transp", 16'(t), 16'd0);

    write_entry(2'd2, 4'd5, 12'hF80);
    lookup(2'd2, 4'd5, "b2i5", rgb, t);
    check("b2i5 red", 16'(rgb[11:8]), 16'hF);
    check("b2i5 green", 16'(rgb[7:4]), 16'h8);
    check("b2i5 blue", 16'(rgb[3:0]), 16'h0);
    lookup(2'd1, 4'd5, "b1i5", rgb, t);
    check("b1i5 rgb", 16'(rgb), 16'h000);

    // Same-cycle write and lookup of bank 0 index 3, then a lookup the cycle after.
    write_entry(2'd0, 4'd3, 12'h456);
    wr_valid = 1'b1; wr_bank = 2'd0; wr_index = 4'd3; wr_color = 12'h123;
    pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'd3;
    cycle();
    wr_valid = 1'b0;
    cycle();
    pix_valid = 1'b0;
    check("rbw early", 16'(out_valid), 16'd0);
    cycle();
    check("rbw old valid", 16'(out_valid), 16'd1);
    check("rbw old rgb", 16'({red, green, blue}), 16'h456);
    cycle();
    check("rbw new valid", 16'(out_valid), 16'd1);
    check("rbw new rgb", 16'({red, green, blue}), 16'h123);
    cycle();
    check("hold valid", 16'(out_valid), 16'd0);
    check("hold rgb", 16'({red, green, blue}), 16'h123);

    // Back-to-back lookups of indices 0,1,2 in bank 0.
    write_entry(2'd0, 4'd1, 12'hABC);
    write_entry(2'd0, 4'd2, 12'h5D7);
    pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'd0;
    cycle();
    pix_index = 4'd1;
    cycle();
    pix_index = 4'd2;
    cycle();
    pix_valid = 1'b0;
    check("b2b0 valid", 16'(out_valid), 16'd1);
    check("b2b0 rgb", 16'({red, green, blue}), 16'h000);
    check("b2b0 transp", 16'(transparent), 16'd1);
    cycle();
    check("b2b1 valid", 16'(out_valid), 16'd1);
    check("b2b1 rgb", 16'({red, green, blue}), 16'hABC);
    check("b2b1 transp", 16'(transparent), 16'd0);
    cycle();
    check("b2b2 valid", 16'(out_valid), 16'd1);
    check("b2b2 rgb", 16'({red, green, blue}), 16'h5D7);
    cycle();
    check("b2b end valid", 16'(out_valid), 16'd0);
    check("b2b hold rgb", 16'({red, green, blue}), 16'h5D7);
    check("b2b hold transp", 16'(transparent), 16'd0);

    // Fade to black over 16 ticks on a white entry; 15*L>>4 is L-1 for L>=1.
    write_entry(2'd3, 4'd7, 12'hFFF);
    lookup(2'd3, 4'd7, "fade lvl16", rgb, t);
    check("fade lvl16 rgb", 16'(rgb), 16'hFFF);
    pulse(1'b1, 1'b0, 1'b0);
    check("fout start busy", 16'(fade_busy), 16'd1);
    check("fout start level", 16'(fade_level), 16'd16);
    for (int k = 1; k <= 16; k++) begin
      pulse(1'b0, 1'b0, 1'b1);
      lvl = 5'(16 - k);
      check("fout level", 16'(fade_level), 16'(lvl));
      check("fout busy", 16'(fade_busy), (k < 16) ? 16'd1 : 16'd0);
      lookup(2'd3, 4'd7, "fout look", rgb, t);
      e = (lvl == 5'd0) ? 4'd0 : 4'(lvl - 5'd1);
      check("fout rgb", 16'(rgb), 16'({e, e, e}));
    end

    // Start and tick together in BLACK: transition only, level stays 0.
    pulse(1'b1, 1'b1, 1'b1);
    check("fin start level", 16'(fade_level), 16'd0);
    check("fin start busy", 16'(fade_busy), 16'd1);
    for (int k = 1; k <= 16; k++) begin
      pulse(1'b0, 1'b0, 1'b1);
      if (k == 3) begin
        pulse(1'b1, 1'b0, 1'b0);
      end
      check("fin level", 16'(fade_level), 16'(k));
      check("fin busy", 16'(fade_busy), (k < 16) ? 16'd1 : 16'd0);
    end
    lookup(2'd3, 4'd7, "fin done", rgb, t);
    check("fin done rgb", 16'(rgb), 16'hFFF);

    // Fade-in requested while already FULL: busy until the next tick, level unchanged.
    pulse(1'b1, 1'b1, 1'b0);
    check("full fin busy", 16'(fade_busy), 16'd1);
    check("full fin level", 16'(fade_level), 16'd16);
    pulse(1'b0, 1'b0, 1'b1);
    check("full fin done busy", 16'(fade_busy), 16'd0);
    check("full fin done level", 16'(fade_level), 16'd16);

    // Reset in the middle of a fade at level 7.
    pulse(1'b1, 1'b0, 1'b0);
    repeat (9) pulse(1'b0, 1'b0, 1'b1);
    check("mid level", 16'(fade_level), 16'd7);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid rst level", 16'(fade_level), 16'd16);
    check("mid rst busy", 16'(fade_busy), 16'd0);
    check("mid rst wr_ready", 16'(wr_ready), 16'd0);
    check("mid rst rgb", 16'({red, green, blue}), 16'h000);
    @(negedge Clk);
    Reset_n = 1'b1;
    start = cyc_cnt;
    repeat (4) cycle();
    // Address 55 is not yet cleared; address 1 already is.
    lookup(2'd3, 4'd7, "init look b3i7", rgb, t);
    check("init look b3i7 rgb", 16'(rgb), 16'hFFF);
    lookup(2'd0, 4'd1, "init look b0i1", rgb, t);
    check("init look b0i1 rgb", 16'(rgb), 16'h000);
    check("init wr_ready low", 16'(wr_ready), 16'd0);
    wait_ready(start, "init2");
    lookup(2'd3, 4'd7, "post b3i7", rgb, t);
    check("post b3i7 rgb", 16'(rgb), 16'h000);
    lookup(2'd2, 4'd5, "post b2i5", rgb, t);
    check("post b2i5 rgb", 16'(rgb), 16'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/palette_bank.md
PALETTE_BANK -- requirements
Module: palette_bank

Interface
REQ-001 Parameter INDEX_W, default 4, colour-index width; each bank holds 2**INDEX_W entries.
REQ-002 Parameter NUM_BANKS, default 4, number of palette banks; BANK_W = max(1, clog2(NUM_BANKS)).
REQ-003 Parameter CH_W, default 4, width of each colour channel; an entry is {R,G,B}, 3*CH_W bits.
REQ-004 Parameter TRANSP_EN, default 1, enables the index-0 transparency flag.
REQ-005 Port Clk, in, 1, the single clock; all state changes on its rising edge.
REQ-006 Port Reset_n, in, 1, asynchronous active-low reset.
REQ-007 Ports: pix_valid in 1, lookup request; pix_bank in BANK_W; pix_index in INDEX_W.
REQ-008 Ports: out_valid out 1; red, green, blue out CH_W each; transparent out 1.
REQ-009 Ports: wr_valid in 1, wr_ready out 1, wr_bank in BANK_W, wr_index in INDEX_W, wr_color in 3*CH_W as {R,G,B}.
REQ-010 Ports: fade_start in 1, fade_dir in 1 (0 = fade to black, 1 = fade from black), frame_tick in 1, fade_busy out 1, fade_level out CH_W+1.

Function
REQ-011 Write control FSM: INIT -> READY; INIT clears every entry to 0, one entry per cycle, ascending address {bank,index}, taking NUM_BANKS*2**INDEX_W cycles.
REQ-012 wr_ready is 0 in INIT and 1 in READY; a write commits on a cycle with wr_valid && wr_ready.
REQ-013 Lookup latency is exactly 2 cycles: pix_valid at edge N gives out_valid=1 with the result after edge N+2; the pipeline accepts one request per cycle with no stalls.
REQ-014 A lookup and a write to the same entry in the same cycle return the old entry (read-before-write).
REQ-015 Lookups during INIT are serviced and return the current, partially cleared contents.
REQ-016 Each output channel = (c * fade_level) >> CH_W, with fade_level in 0..2**CH_W; at 2**CH_W the output equals c exactly.
REQ-017 transparent = TRANSP_EN && (pix_index == 0), pipelined alongside the colour. Colour is still output when transparent is set.
REQ-018 When out_valid is 0, red/green/blue/transparent hold their last values.
REQ-019 Fade FSM states: FULL (level = 2**CH_W), FADE_OUT, BLACK (level = 0), FADE_IN.
REQ-020 fade_start with fade_dir=0 in FULL or BLACK -> FADE_OUT; with fade_dir=1 -> FADE_IN.
REQ-021 fade_start while fade_busy is ignored.
REQ-022 In FADE_OUT, each frame_tick decrements the level by 1; on reaching 0 the FSM enters BLACK.
REQ-023 In FADE_IN, each frame_tick increments the level by 1; on reaching 2**CH_W the FSM enters FULL.
REQ-024 The level never wraps; fade_start toward the current end state completes on the next frame_tick with no change in level.
REQ-025 fade_busy = 1 only in FADE_OUT or FADE_IN.
REQ-026 If fade_start and frame_tick arrive in the same cycle, only the state transition takes effect; the tick is dropped.
REQ-027 The level used for scaling is sampled in pipeline stage 1, together with the RAM read.

Reset
REQ-028 On Reset_n low, asynchronously and at any time, including mid-fade, mid-write or mid-INIT: write FSM to INIT at address 0, fade FSM to FULL, fade_level = 2**CH_W.
REQ-029 On Reset_n low, out_valid, red, green, blue, transparent, wr_ready and fade_busy are 0.
REQ-030 Pipeline valid bits clear on reset; in-flight lookups are discarded.
REQ-031 INIT begins on the first Clk edge after Reset_n deasserts.

Structure
REQ-032 A shared package palette_pkg holds the fade state enum, the write state enum and a parametrised rgb struct/width helper.
REQ-033 One sub-module, palette_scaler, performs single-channel (c * level) >> CH_W combinationally and is instantiated three times.
REQ-034 Storage is a single synchronous-read array of NUM_BANKS*2**INDEX_W entries addressed {bank,index}.

Verification
REQ-035 Reset, then count cycles to wr_ready=1 -> exactly 64 cycles at default parameters; a lookup of any entry then returns 0,0,0.
REQ-036 Write bank 2 index 5 = 0xF80, then look it up -> red=F, green=8, blue=0 two cycles later; a bank 1 index 5 lookup returns 0x000.
REQ-037 Same-cycle write of 0x123 and lookup of the same entry -> old value returned; a lookup on the next cycle returns 0x123.
REQ-038 Entry 0xFFF with fade_start dir=0 and 16 frame_ticks -> level steps 16..0, red reads F,E,...,0, fade_busy drops exactly at BLACK; dir=1 then restores F after 16 ticks.
REQ-039 Lookup of index 0 -> transparent=1; index 1 -> transparent=0; back-to-back lookups every cycle produce one out_valid per cycle in order.
REQ-040 Assert Reset_n low mid-fade at level 7 -> fade_level=16 and fade_busy=0 immediately; INIT reruns and the table reads 0.
